// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encodings, parity codes and default oversampling.
// The receiver imports the same package, so the encodings must stay stable.
package uart_transmitter_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DEFAULT_OVERSAMPLING = 16;

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side transmit interface: baud tick, start request and data in; serial line and status out.
interface uart_transmitter_if #(
    parameter int NDATA_BITS = 8
);
    logic                  i_baud;
    logic                  i_tx_start;
    logic [NDATA_BITS-1:0] i_data;
    logic                  o_tx;
    logic                  o_busy;
    logic                  o_tx_done;

    modport master (
        output i_baud, i_tx_start, i_data,
        input  o_tx, o_busy, o_tx_done
    );

    modport slave (
        input  i_baud, i_tx_start, i_data,
        output o_tx, o_busy, o_tx_done
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// One FSM plus shift register; bit timing comes from an external baud tick.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int NDATA_BITS   = 8,
    parameter int NSTOP_BITS   = 1,
    parameter int OVERSAMPLING = DEFAULT_OVERSAMPLING,
    parameter int PARITY       = PAR_NONE
) (
    input  logic              i_clock,
    input  logic              i_reset,
    uart_transmitter_if.slave bus
);

    localparam int TICK_W = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
    localparam int DCNT_W = $clog2(NDATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING - 1);
    localparam logic [DCNT_W-1:0] DATA_LAST = DCNT_W'(NDATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(NSTOP_BITS - 1);

    logic [2:0]            state;
    logic [TICK_W-1:0]     tick_cnt;
    logic [DCNT_W-1:0]     data_cnt;
    logic                  stop_cnt;
    logic [NDATA_BITS-1:0] shift_q;
    logic                  parity_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    function automatic logic calc_parity(input logic [NDATA_BITS-1:0] d);
        if (PARITY == PAR_ODD)
            return ~(^d);
        return ^d;
    endfunction

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            data_cnt <= '0;
            stop_cnt <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_IDLE) begin
                tx_q   <= 1'b1;
                busy_q <= 1'b0;
                if (bus.i_tx_start) begin
                    shift_q  <= bus.i_data;
                    parity_q <= calc_parity(bus.i_data);
                    tick_cnt <= '0;
                    state    <= ST_START;
                    tx_q     <= 1'b0;
                    busy_q   <= 1'b1;
                end
            end else if (bus.i_baud) begin
                if (tick_cnt != TICK_LAST) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end else begin
                    // Bit boundary: register the next line value
                    tick_cnt <= '0;
                    case (state)
                        ST_START: begin
                            tx_q     <= shift_q[0];
                            data_cnt <= '0;
                            state    <= ST_DATA;
                        end
                        ST_DATA: begin
                            if (data_cnt == DATA_LAST) begin
                                if (PARITY != PAR_NONE) begin
                                    tx_q  <= parity_q;
                                    state <= ST_PARITY;
                                end else begin
                                    tx_q     <= 1'b1;
                                    stop_cnt <= 1'b0;
                                    state    <= ST_STOP;
                                end
                            end else begin
                                shift_q  <= shift_q >> 1;
                                tx_q     <= shift_q[1];
                                data_cnt <= data_cnt + 1'b1;
                            end
                        end
                        ST_PARITY: begin
                            tx_q     <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (stop_cnt == STOP_LAST) begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state  <= ST_IDLE;
                            tx_q   <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_tx_done = done_q;

endmodule
